permute_sched: RTL and testbench

- Round-robin scheduler that shares one permutation engine (Idle/Init/Load/Calc/Ready sequencer, one `ready` pulse per round) among N requesters.
- Arbitrates requests and issues the single-cycle engine start.
- Routes the engine's per-round `read` strobe to the owning requester, counts rounds and reports completion or error per requester.
- Sits between the requester-side input buffers and the permute engine's control unit.

---
 rtl/permute_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/permute_sched.sv | 148 ++++++++++++++
 tb/tb_permute_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/permute_pkg.sv
// -----------------------------------------------------------------------------
// permute_pkg
// Shared definitions for the permutation-engine scheduler.
//   - FSM state encodings for the scheduler sequencer
//   - default job length (engine rounds per job) and watchdog limit
//   - watchdog counter width
// -----------------------------------------------------------------------------
package permute_pkg;

    // Scheduler sequencer states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Engine rounds expected in a complete job
    localparam int ROUNDS_DEF  = 64;
    // Cycles without engine progress before a job is declared failed
    localparam int TIMEOUT_DEF = 1024;
    // Watchdog width; the counter saturates at all-ones
    localparam int WD_W        = 11;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Returns the first asserted request bit
// found searching upward from ptr, wrapping past N-1 back to 0.
// Ports:
//   req   in  N    request vector
//   ptr   in  IDW  index holding highest priority (must be < N)
//   grant out N    one-hot winner, 0 when no request
//   idx   out IDW  binary index of winner, 0 when no request
//   hit   out 1    at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           hit
);

    // Two passes keep every select index a loop constant: the first pass
    // only accepts bits at or above ptr, the second supplies the wrap.
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!hit && req[k] && (k >= int'(ptr))) begin
                hit      = 1'b1;
                grant[k] = 1'b1;
                idx      = IDW'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!hit && req[k]) begin
                hit      = 1'b1;
                grant[k] = 1'b1;
                idx      = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/permute_sched.sv
// -----------------------------------------------------------------------------
// permute_sched
// Round-robin scheduler sharing one permutation engine among N requesters.
// Arbitrates, issues the engine start, steers the engine read strobe to the
// owner, counts rounds and reports completion / error per job.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req[N]            level requests, held until done
//   grant[N]          one-hot owner (0 when none)
//   gnt_id[IDW]       binary owner index (0 when none)
//   rd_en[N]          grant gated by eng_read (combinational)
//   done[N]           one-cycle pulse to the owner at job end
//   err               pulses with done when the job ended abnormally
//   busy              high whenever the sequencer is not idle
//   round_cnt[7]      rounds seen in current / last job
//   eng_start         one-cycle engine start
//   eng_total_ready   engine idle flag
//   eng_ready         engine per-round pulse
//   eng_read          engine read strobe
// -----------------------------------------------------------------------------
module permute_sched
    import permute_pkg::*;
#(
    parameter int N       = 2,
    parameter int ROUNDS  = ROUNDS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int IDW     = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   rd_en,
    output logic [N-1:0]   done,
    output logic           err,
    output logic           busy,
    output logic [6:0]     round_cnt,
    output logic           eng_start,
    input  logic           eng_total_ready,
    input  logic           eng_ready,
    input  logic           eng_read
);

    logic [2:0]      state;
    logic [IDW-1:0]  ptr;
    logic [WD_W-1:0] wd;

    logic [N-1:0]    arb_grant;
    logic [IDW-1:0]  arb_id;
    logic            arb_hit;

    logic            timeout;
    logic [WD_W-1:0] wd_inc;
    logic [6:0]      rc_next;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_id),
        .hit   (arb_hit)
    );

    assign timeout = (32'(wd) >= TIMEOUT);
    assign wd_inc  = (wd == '1) ? wd : wd + WD_W'(1);
    // Includes a round arriving in the same cycle as the job end.
    assign rc_next = round_cnt + {6'd0, eng_ready};

    assign busy  = (state != ST_IDLE);
    assign rd_en = grant & {N{eng_read}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            gnt_id    <= '0;
            done      <= '0;
            err       <= 1'b0;
            eng_start <= 1'b0;
            round_cnt <= '0;
            ptr       <= '0;
            wd        <= '0;
        end else begin
            eng_start <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_hit && eng_total_ready) begin
                        grant     <= arb_grant;
                        gnt_id    <= arb_id;
                        round_cnt <= '0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    // The start leaves as a registered pulse one cycle
                    // after the grant becomes visible.
                    eng_start <= 1'b1;
                    wd        <= '0;
                    state     <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    wd <= wd_inc;
                    if (!eng_total_ready) begin
                        state <= ST_RUN;
                    end else if (timeout) begin
                        state <= ST_DONE;
                        done  <= grant;
                        err   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    round_cnt <= rc_next;
                    wd        <= eng_ready ? '0 : wd_inc;
                    if (eng_total_ready) begin
                        state <= ST_DONE;
                        done  <= grant;
                        err   <= (32'(rc_next) != ROUNDS);
                    end else if (timeout && !eng_ready) begin
                        state <= ST_DONE;
                        done  <= grant;
                        err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    grant  <= '0;
                    gnt_id <= '0;
                    // Owner drops to lowest priority for the next pick.
                    if (gnt_id == IDW'(N - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= gnt_id + IDW'(1);
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_permute_sched.sv
// -----------------------------------------------------------------------------
// tb_permute_sched
// Directed + randomized bench for permute_sched (N=2, TIMEOUT=16). A
// behavioural engine is driven cycle by cycle from one initial block; the
// expected owner, round count and error come from a round-robin reference.
// -----------------------------------------------------------------------------
module tb_permute_sched;

    localparam int N       = 2;
    localparam int IDW     = 3;
    localparam int ROUNDS  = 64;
    localparam int TIMEOUT = 16;

    localparam int M_NORMAL = 0;
    localparam int M_COINC  = 1;
    localparam int M_STUCK  = 2;
    localparam int M_STALL  = 3;
    localparam int M_RESET  = 4;

    localparam int R_RELEASE = 0;
    localparam int R_HOLD    = 1;
    localparam int R_DROP    = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   rd_en;
    logic [N-1:0]   done;
    logic           err;
    logic           busy;
    logic [6:0]     round_cnt;
    logic           eng_start;
    logic           eng_total_ready;
    logic           eng_ready;
    logic           eng_read;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    permute_sched #(
        .N       (N),
        .ROUNDS  (ROUNDS),
        .TIMEOUT (TIMEOUT),
        .IDW     (IDW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .grant           (grant),
        .gnt_id          (gnt_id),
        .rd_en           (rd_en),
        .done            (done),
        .err             (err),
        .busy            (busy),
        .round_cnt       (round_cnt),
        .eng_start       (eng_start),
        .eng_total_ready (eng_total_ready),
        .eng_ready       (eng_ready),
        .eng_read        (eng_read)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester at or after p, wrapping modulo N.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic run_cycle(input logic rdy, input logic tr, input logic [N-1:0] oh);
        logic rd;
        rd              = 1'($urandom);
        eng_ready       = rdy;
        eng_total_ready = tr;
        eng_read        = rd;
        #1;
        chk("rd_en", 32'(rd ? oh : {N{1'b0}}), 32'(rd_en));
        chk("done_run", 32'(done), 32'd0);
        step();
    endtask

    task automatic do_job(input logic [N-1:0] r, input int k, input int mode, input int rmode);
        int         own;
        int         waited;
        int         gap;
        int         exp_rc;
        logic       exp_err;
        logic [N-1:0] oh;
        own             = pick(r, ptr_m);
        oh              = N'(1) << own;
        req             = r;
        eng_total_ready = 1'b1;
        eng_ready       = 1'b0;
        eng_read        = 1'b0;
        step();
        chk("grant", 32'(grant), 32'(oh));
        chk("gnt_id", 32'(gnt_id), 32'(own));
        chk("busy_start", 32'(busy), 32'd1);
        chk("start_early", 32'(eng_start), 32'd0);
        chk("rc_clear", 32'(round_cnt), 32'd0);
        step();
        chk("eng_start", 32'(eng_start), 32'd1);
        if (rmode == R_DROP) req = '0;
        if (mode == M_STUCK) begin
            waited = 0;
            while (done == '0 && waited < TIMEOUT + 5) begin
                step();
                waited++;
            end
            chk("stuck_latency", 32'(waited), 32'(TIMEOUT + 1));
        end else begin
            run_cycle(1'b0, 1'b0, oh);
            chk("start_pulse", 32'(eng_start), 32'd0);
            for (int ri = 0; ri < k; ri++) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) run_cycle(1'b0, 1'b0, oh);
                run_cycle(1'b1, (mode == M_COINC) && (ri == k - 1), oh);
            end
            if (mode == M_RESET) begin
                rst = 1'b1;
                #1;
                chk("rst_grant", 32'(grant), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_rc", 32'(round_cnt), 32'd0);
                chk("rst_gnt_id", 32'(gnt_id), 32'd0);
                step();
                rst             = 1'b0;
                eng_total_ready = 1'b1;
                eng_ready       = 1'b0;
                req             = '0;
                ptr_m           = 0;
                return;
            end
            if (mode == M_NORMAL) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) run_cycle(1'b0, 1'b0, oh);
                run_cycle(1'b0, 1'b1, oh);
            end
            if (mode == M_STALL) begin
                eng_ready = 1'b0;
                waited    = 0;
                while (done == '0 && waited < TIMEOUT + 5) begin
                    step();
                    waited++;
                end
                chk("stall_latency", 32'(waited), 32'(TIMEOUT + 1));
            end
        end
        exp_err = (mode == M_STUCK) || (mode == M_STALL) || (k != ROUNDS);
        exp_rc  = (mode == M_STUCK) ? 0 : k;
        chk("done", 32'(done), 32'(oh));
        chk("err", 32'(err), 32'(exp_err));
        chk("rc_final", 32'(round_cnt), 32'(exp_rc));
        chk("busy_done", 32'(busy), 32'd1);
        eng_total_ready = 1'b1;
        eng_ready       = 1'b0;
        if (rmode != R_HOLD) req = '0;
        step();
        chk("done_clr", 32'(done), 32'd0);
        chk("err_clr", 32'(err), 32'd0);
        chk("grant_clr", 32'(grant), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rc_hold", 32'(round_cnt), 32'(exp_rc));
        ptr_m = (own + 1) % N;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] r;
        rst             = 1'b1;
        req             = '0;
        eng_total_ready = 1'b1;
        eng_ready       = 1'b0;
        eng_read        = 1'b0;
        step();
        step();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_gnt_id", 32'(gnt_id), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_start", 32'(eng_start), 32'd0);
        chk("reset_rc", 32'(round_cnt), 32'd0);
        eng_read = 1'b1;
        #1;
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        eng_read = 1'b0;
        rst      = 1'b0;
        step();
        chk("idle_no_req", 32'(grant), 32'd0);

        // single job
        do_job(2'b01, 64, M_NORMAL, R_RELEASE);
        // contention: req held, owners alternate
        do_job(2'b11, 64, M_NORMAL, R_HOLD);
        do_job(2'b11, 64, M_NORMAL, R_HOLD);
        do_job(2'b11, 64, M_NORMAL, R_HOLD);
        do_job(2'b11, 64, M_NORMAL, R_RELEASE);
        // short job
        do_job(2'b01, 63, M_NORMAL, R_RELEASE);
        // last round coincides with total_ready; req dropped mid-job
        do_job(2'b10, 64, M_COINC, R_DROP);
        // engine never acknowledges start
        do_job(2'b01, 0, M_STUCK, R_RELEASE);
        // engine stalls in RUN
        do_job(2'b10, 20, M_STALL, R_RELEASE);

        // engine busy externally: no grant, no start
        req             = 2'b10;
        eng_total_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("busy_eng_grant", 32'(grant), 32'd0);
            chk("busy_eng_start", 32'(eng_start), 32'd0);
        end
        do_job(2'b10, 64, M_NORMAL, R_RELEASE);

        // leave ptr at 1, then reset mid-job; priority must return to 0
        do_job(2'b01, 64, M_NORMAL, R_RELEASE);
        do_job(2'b01, 30, M_RESET, R_RELEASE);
        do_job(2'b11, 64, M_NORMAL, R_RELEASE);

        // randomized jobs
        for (int t = 0; t < 6; t++) begin
            r = N'($urandom_range(1, 3));
            do_job(r, $urandom_range(62, 66), $urandom_range(0, 1), $urandom_range(0, 2));
        end
        req = '0;
        step();
        step();
        chk("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
